// File: rtl/uart_word_rx_if.sv
// uart_word_rx_if
// Handshake bundle for the UART word reassembler.
//
// Parameters:
//   WORD_WIDTH - width of the assembled word
//   BYTE_WIDTH - width of one incoming byte
//
// Signals:
//   in_data   - byte from the byte receiver
//   in_valid  - in_data is valid
//   in_ready  - reassembler accepts a byte this cycle
//   out_data  - assembled word, byte k at bits [k*BYTE_WIDTH +: BYTE_WIDTH]
//   out_valid - out_data holds a complete word
//   out_ready - consumer accepts the word
//   frame_err - one-cycle pulse when a stalled partial word is dropped
//   csum_err  - one-cycle pulse when the trailing checksum does not match
//
// Modports:
//   master - the surrounding environment (byte source and word consumer)
//   slave  - the reassembler itself
interface uart_word_rx_if #(
  parameter int WORD_WIDTH = 256,
  parameter int BYTE_WIDTH = 8
);

  logic [BYTE_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_err;
  logic                  csum_err;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  frame_err,
    input  csum_err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output frame_err,
    output csum_err
  );

endinterface

// File: rtl/uart_word_rx.sv
// uart_word_rx
// Reader end of the wide-word UART link. Sits behind the byte receiver and
// rebuilds WORD_WIDTH-bit words from a byte stream sent least-significant
// byte first. Each completed word is offered on a valid/ready output. A word
// that stalls for too long between bytes is dropped so the link can
// resynchronise on the next byte.
//
// Parameters:
//   WORD_WIDTH     - assembled word width, an integer multiple (>= 2) of BYTE_WIDTH
//   BYTE_WIDTH     - width of the incoming byte stream
//   TIMEOUT_CYCLES - maximum idle cycles between bytes of one word (>= 2)
//
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous, active-high reset
//   bus - uart_word_rx_if.slave: in_data/in_valid/in_ready byte input,
//         out_data/out_valid/out_ready word output, frame_err and csum_err pulses
//
// Optional feature (macro UART_WORD_RX_CHECKSUM_EN):
//   When defined, every word is followed by one checksum byte equal to the
//   XOR of its data bytes. A mismatch drops the word and pulses csum_err.
//   When undefined, no checksum byte is expected and csum_err is tied low.
module uart_word_rx #(
  parameter int WORD_WIDTH     = 256,
  parameter int BYTE_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic          clk,
  input logic          rst,
  uart_word_rx_if.slave bus
);

  localparam int NBYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam int CNTW   = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  // Index of the byte that ends a frame: the top data lane, or the checksum
  // byte right after it. Lanes below that index are held in the assembly
  // register until the frame completes.
`ifdef UART_WORD_RX_CHECKSUM_EN
  localparam int LAST_IDX = NBYTES;
`else
  localparam int LAST_IDX = NBYTES - 1;
`endif
  localparam int ASM_LANES = LAST_IDX;

  localparam logic [CNTW-1:0] LAST_CNT     = CNTW'(LAST_IDX);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 2);

  // Reject parameter combinations that cannot form a word or a usable timeout.
  generate
    if (((WORD_WIDTH % BYTE_WIDTH) != 0) || (NBYTES < 2)) begin : g_bad_width
      $error("uart_word_rx: WORD_WIDTH must be a multiple of BYTE_WIDTH with at least 2 bytes");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_word_rx: TIMEOUT_CYCLES must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNTW-1:0]                 byte_cnt_q;
  logic [TW-1:0]                   tcnt_q;
  logic [ASM_LANES*BYTE_WIDTH-1:0] asm_q;
  logic [WORD_WIDTH-1:0]           out_data_q;
  logic [WORD_WIDTH-1:0]           completed_word;
  logic                            frame_err_q;

  logic accept;
  logic last_byte;
  logic word_done;
  logic timeout_hit;

  // A byte is taken whenever the source offers one and we are not holding a
  // finished word. last_byte marks the byte that closes the frame.
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = accept && (byte_cnt_q == LAST_CNT);

  // The timeout fires on the idle cycle that would bring the counter to
  // TIMEOUT_CYCLES-1. A byte arriving on that same cycle wins, so the check
  // is qualified by !accept.
  assign timeout_hit = (state_q == COLLECT) && !accept && (tcnt_q == TIMEOUT_LAST);

`ifdef UART_WORD_RX_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] csum_q;
  logic                  csum_err_q;
  logic                  csum_bad;

  assign csum_bad       = last_byte && (csum_q != bus.in_data);
  assign word_done      = last_byte && !csum_bad;
  assign completed_word = asm_q;

  // Running XOR of the data bytes. The first byte of a frame reloads it so
  // no state leaks from a dropped or completed frame. The checksum byte is
  // folded in as well, which is harmless because the next frame reloads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q     <= '0;
      csum_err_q <= 1'b0;
    end else begin
      csum_err_q <= csum_bad;
      if (accept) begin
        if (state_q == IDLE) begin
          csum_q <= bus.in_data;
        end else begin
          csum_q <= csum_q ^ bus.in_data;
        end
      end
    end
  end

  assign bus.csum_err = csum_err_q;
`else
  assign word_done      = last_byte;
  assign completed_word = {bus.in_data, asm_q};
  assign bus.csum_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A bad checksum ends the frame like a timeout does,
  // dropping straight back to IDLE without ever presenting the word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (word_done) begin
          state_d = HOLD;
        end else if (last_byte || timeout_hit) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state only, so out_ready never has
  // a combinational path to in_ready.
  always_comb begin
    bus.in_ready  = (state_q != HOLD);
    bus.out_valid = (state_q == HOLD);
  end

  // Datapath: byte counter, inter-byte timeout counter, lane writes, output
  // word register and the frame error pulse. out_data_q is only loaded by a
  // completed good frame, so it keeps the last word across handshakes,
  // timeouts and checksum failures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q  <= '0;
      tcnt_q      <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= timeout_hit;

      if (accept) begin
        if (last_byte) begin
          byte_cnt_q <= '0;
        end else begin
          byte_cnt_q <= byte_cnt_q + CNTW'(1);
        end
      end else if (timeout_hit) begin
        byte_cnt_q <= '0;
      end

      if ((state_q != COLLECT) || accept || timeout_hit) begin
        tcnt_q <= '0;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end

      for (int k = 0; k < ASM_LANES; k++) begin
        if (accept && (byte_cnt_q == CNTW'(k))) begin
          asm_q[k*BYTE_WIDTH +: BYTE_WIDTH] <= bus.in_data;
        end
      end

      if (word_done) begin
        out_data_q <= completed_word;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx
// Bench for uart_word_rx with WORD_WIDTH=32, BYTE_WIDTH=8, TIMEOUT_CYCLES=16.
// A transaction-level model (a byte queue, an idle-cycle count and a held
// word) predicts in_ready, out_valid, out_data, frame_err and csum_err; a
// compare process checks them on every falling edge. Directed scenarios add
// hand-computed literal expectations. Define UART_WORD_RX_CHECKSUM_EN to
// exercise the checksum build.
module tb_uart_word_rx;

  localparam int WW = 32;
  localparam int BW = 8;
  localparam int TO = 16;
  localparam int NB = WW / BW;
`ifdef UART_WORD_RX_CHECKSUM_EN
  localparam int FRAME_BYTES = NB + 1;
`else
  localparam int FRAME_BYTES = NB;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_word_rx_if #(.WORD_WIDTH(WW), .BYTE_WIDTH(BW)) bus ();

  uart_word_rx #(
    .WORD_WIDTH    (WW),
    .BYTE_WIDTH    (BW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks       = 0;
  int failures     = 0;
  int cyc          = 0;
  int last_acc     = 0;
  int frame_pulses = 0;
  bit done         = 1'b0;

  logic [7:0]  m_bytes[$];
  bit          m_hold  = 1'b0;
  int          m_idle  = 0;
  bit          m_frame = 1'b0;
  bit          m_csum  = 1'b0;
  logic [31:0] m_out   = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour: a held word blocks input
  // until consumed; otherwise an offered byte joins the frame, and a partial
  // frame left idle for TO-1 edges is dropped with a frame error.
  task automatic modelStep();
    bit good;
`ifdef UART_WORD_RX_CHECKSUM_EN
    logic [7:0] x;
`endif
    m_frame = 1'b0;
    m_csum  = 1'b0;
    if (m_hold) begin
      if (bus.out_ready) m_hold = 1'b0;
    end else if (bus.in_valid) begin
      m_bytes.push_back(bus.in_data);
      m_idle = 0;
      if (m_bytes.size() == FRAME_BYTES) begin
`ifdef UART_WORD_RX_CHECKSUM_EN
        x = '0;
        for (int k = 0; k < NB; k++) x = x ^ m_bytes[k];
        good = (x == m_bytes[NB]);
`else
        good = 1'b1;
`endif
        if (good) begin
          m_out = '0;
          for (int k = 0; k < NB; k++) m_out = m_out | (32'(m_bytes[k]) << (8 * k));
          m_hold = 1'b1;
        end else begin
          m_csum = 1'b1;
        end
        m_bytes.delete();
      end
    end else if (m_bytes.size() != 0) begin
      m_idle++;
      if (m_idle == TO - 1) begin
        m_frame = 1'b1;
        m_bytes.delete();
        m_idle = 0;
      end
    end
  endtask

  // Reference model advances on every rising edge and is cleared by reset.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_bytes.delete();
        m_hold  = 1'b0;
        m_idle  = 0;
        m_frame = 1'b0;
        m_csum  = 1'b0;
        m_out   = '0;
      end else begin
        modelStep();
      end
    end
  end

  // Free-running cycle count used to time accepts and error pulses.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Compare DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        checkOutput("in_ready",  32'(bus.in_ready),  32'(!m_hold));
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_hold));
        checkOutput("out_data",  bus.out_data,       m_out);
        checkOutput("frame_err", 32'(bus.frame_err), 32'(m_frame));
        checkOutput("csum_err",  32'(bus.csum_err),  32'(m_csum));
        if (bus.frame_err) frame_pulses++;
      end
    end
  end

  // Offer one byte and hold it until accepted; returns just after the
  // accepting edge with in_valid dropped and last_acc set to that edge.
  task automatic applyStimulus(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      failures++;
      $display("[TB] FAIL byte_accept: in_ready got 0 required 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    last_acc     = cyc;
  endtask

  // Send a word LSB first, optionally idling gap1 edges after byte 0, and
  // append the XOR checksum byte in the checksum build.
  task automatic sendWord(input logic [31:0] w, input int gap1);
`ifdef UART_WORD_RX_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
`endif
    for (int k = 0; k < NB; k++) begin
      if (k == 1) repeat (gap1) @(posedge clk);
      applyStimulus(w[8*k +: 8]);
`ifdef UART_WORD_RX_CHECKSUM_EN
      x = x ^ w[8*k +: 8];
`endif
    end
`ifdef UART_WORD_RX_CHECKSUM_EN
    applyStimulus(x);
`endif
  endtask

  // Abort guard in case a wait never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got time limit required normal completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int p0;
    int seen;
    int pulses;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_data", bus.out_data, 32'h0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'h0);
    rst = 1'b0;

    $display("[TB] basic assembly");
    sendWord(32'h12345678, 0);
    checkOutput("basic_valid_rise", 32'(bus.out_valid), 32'h1);
    checkOutput("basic_word", bus.out_data, 32'h12345678);
    @(posedge clk);
    #1;
    checkOutput("basic_valid_fall", 32'(bus.out_valid), 32'h0);

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    sendWord(32'hDEADBEEF, 0);
    fork
      sendWord(32'h01020304, 0);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'h0);
          checkOutput("bp_held_word", bus.out_data, 32'hDEADBEEF);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
      end
    join
    checkOutput("bp_second_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("bp_second_word", bus.out_data, 32'h01020304);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] timeout");
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    t0     = last_acc;
    seen   = -1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_err) begin
        pulses++;
        if (seen < 0) seen = cyc - t0;
      end
    end
    checkOutput("timeout_pulse_count", 32'(pulses), 32'd1);
    checkOutput("timeout_latency", 32'(seen), 32'd15);
    sendWord(32'h04030201, 0);
    checkOutput("after_timeout_word", bus.out_data, 32'h04030201);

    $display("[TB] timeout boundary");
    p0 = frame_pulses;
    applyStimulus(8'h10);
    t0 = last_acc;
    repeat (14) @(posedge clk);
    applyStimulus(8'h20);
    checkOutput("boundary_gap", 32'(last_acc - t0), 32'd15);
    applyStimulus(8'h30);
    applyStimulus(8'h40);
`ifdef UART_WORD_RX_CHECKSUM_EN
    applyStimulus(8'h40);
`endif
    checkOutput("boundary_word", bus.out_data, 32'h40302010);
    checkOutput("boundary_no_frame_err", 32'(frame_pulses - p0), 32'd0);

    $display("[TB] reset mid-word");
    p0 = frame_pulses;
    applyStimulus(8'h99);
    applyStimulus(8'h98);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_out_data", bus.out_data, 32'h0);
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendWord(32'h44332211, 0);
    checkOutput("midreset_word", bus.out_data, 32'h44332211);
    checkOutput("midreset_no_frame_err", 32'(frame_pulses - p0), 32'd0);

`ifdef UART_WORD_RX_CHECKSUM_EN
    $display("[TB] checksum");
    @(posedge clk);
    #1;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    applyStimulus(8'h08);
    applyStimulus(8'h0F);
    checkOutput("csum_good_valid", 32'(bus.out_valid), 32'h1);
    checkOutput("csum_good_word", bus.out_data, 32'h08040201);
    @(posedge clk);
    #1;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    applyStimulus(8'h04);
    applyStimulus(8'h08);
    applyStimulus(8'h0E);
    checkOutput("csum_bad_pulse", 32'(bus.csum_err), 32'h1);
    checkOutput("csum_bad_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("csum_bad_keeps_word", bus.out_data, 32'h08040201);
    @(posedge clk);
    #1;
    checkOutput("csum_bad_pulse_end", 32'(bus.csum_err), 32'h0);
`endif

    repeat (3) @(posedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
